// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline boundary with a two-entry skid buffer.
//
// Slot 0 is the main entry and feeds the decode-facing outputs. Slot 1 is
// the skid entry. It only fills when decode stalls while fetch is still
// offering. Every output comes straight from a flop:
// - f_ready is registered as "skid slot free", so d_ready never reaches it
//   combinationally.
// - d_instr is its own register. It is forced to NOP_INSTR whenever the
//   next state is EMPTY.
module if_id_skid_reg #(
    parameter int          ADDR_W    = 32,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  f_pc,
    input  logic [INSTR_W-1:0] f_instr,
    input  logic               f_valid,
    output logic               f_ready,
    input  logic               flush,
    output logic               d_valid,
    input  logic               d_ready,
    output logic [ADDR_W-1:0]  d_pc,
    output logic [ADDR_W-1:0]  d_pc_plus4,
    output logic [INSTR_W-1:0] d_instr,
    output logic [1:0]         occupancy
);

    // The state encoding equals the number of live entries, so occupancy is
    // simply the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    state_t state_reg;
    state_t state_next;

    // Handshake qualifiers. Both use registered outputs only.
    logic accept;
    logic consume;

    // Per-slot load enables and the main-slot source select.
    logic [1:0] load_en;
    logic       load_from_skid;

    // Per-slot entry storage. Index 0 is main and index 1 is skid.
    logic [1:0][ADDR_W-1:0]  slot_pc_reg;
    logic [1:0][ADDR_W-1:0]  slot_pc4_reg;
    logic [1:0][INSTR_W-1:0] slot_instr_reg;

    logic [1:0][ADDR_W-1:0]  slot_pc_next;
    logic [1:0][ADDR_W-1:0]  slot_pc4_next;
    logic [1:0][INSTR_W-1:0] slot_instr_next;

    // Registered output copies.
    logic               d_valid_reg;
    logic               f_ready_reg;
    logic [INSTR_W-1:0] d_instr_reg;
    logic [INSTR_W-1:0] d_instr_next;

    // pc+4 is computed once, at capture, and truncates naturally to ADDR_W.
    logic [ADDR_W-1:0] fetch_pc_plus4;

    assign fetch_pc_plus4 = f_pc + ADDR_W'(4);
    assign accept         = f_valid & f_ready_reg;
    assign consume        = d_valid_reg & d_ready;

    // Next-state and slot-load decisions for the occupancy FSM.
    always_comb begin
        state_next     = state_reg;
        load_en        = 2'b00;
        load_from_skid = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    load_en[0] = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    // Back-to-back: the new entry replaces the consumed one.
                    load_en[0] = 1'b1;
                end else if (accept) begin
                    // Decode stalled, so park the new entry in the skid slot.
                    load_en[1] = 1'b1;
                    state_next = TWO;
                end else if (consume) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // f_ready is low here, so only a consume can move things.
                if (consume) begin
                    load_en[0]     = 1'b1;
                    load_from_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        // A redirect discards everything, including any offer on this edge.
        if (flush) begin
            state_next     = EMPTY;
            load_en        = 2'b00;
            load_from_skid = 1'b0;
        end
    end

    // Per-slot data sources. The main slot may refill from the skid slot.
    // The skid slot only ever loads from fetch.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot_src
            if (gi == 0) begin : g_main
                assign slot_pc_next[gi]    = load_from_skid ? slot_pc_reg[1]    : f_pc;
                assign slot_pc4_next[gi]   = load_from_skid ? slot_pc4_reg[1]   : fetch_pc_plus4;
                assign slot_instr_next[gi] = load_from_skid ? slot_instr_reg[1] : f_instr;
            end else begin : g_skid
                assign slot_pc_next[gi]    = f_pc;
                assign slot_pc4_next[gi]   = fetch_pc_plus4;
                assign slot_instr_next[gi] = f_instr;
            end
        end
    endgenerate

    // What decode will see after this edge. NOP whenever nothing is live.
    always_comb begin
        d_instr_next = d_instr_reg;
        if (state_next == EMPTY) begin
            d_instr_next = NOP_W;
        end else if (load_en[0]) begin
            d_instr_next = slot_instr_next[0];
        end
    end

    // State and handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= EMPTY;
            d_valid_reg <= 1'b0;
            f_ready_reg <= 1'b1;
            d_instr_reg <= NOP_W;
        end else begin
            state_reg   <= state_next;
            d_valid_reg <= (state_next != EMPTY);
            f_ready_reg <= (state_next != TWO);
            d_instr_reg <= d_instr_next;
        end
    end

    // Slot storage. A slot holds its value unless it is explicitly loaded,
    // which keeps the presented entry stable while decode stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_pc_reg    <= '0;
            slot_pc4_reg   <= '0;
            slot_instr_reg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load_en[i]) begin
                    slot_pc_reg[i]    <= slot_pc_next[i];
                    slot_pc4_reg[i]   <= slot_pc4_next[i];
                    slot_instr_reg[i] <= slot_instr_next[i];
                end
            end
        end
    end

    assign f_ready    = f_ready_reg;
    assign d_valid    = d_valid_reg;
    assign d_pc       = slot_pc_reg[0];
    assign d_pc_plus4 = slot_pc4_reg[0];
    assign d_instr    = d_instr_reg;
    assign occupancy  = state_reg;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg. Each scenario task drives stimulus and
// checks outputs #1 after the rising edge against hand-computed values.
// Status triples are packed as {d_valid, occupancy[1:0], f_ready}.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_ready;
    logic        flush;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_pc_plus4;
    logic [31:0] d_instr;
    logic [1:0]  occupancy;

    int vectors = 0;
    int errors  = 0;

    localparam logic [3:0] ST_EMPTY = 4'b0001;
    localparam logic [3:0] ST_ONE   = 4'b1011;
    localparam logic [3:0] ST_TWO   = 4'b1100;

    if_id_skid_reg #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .NOP_INSTR(32'h00000000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .flush     (flush),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_pc      (d_pc),
        .d_pc_plus4(d_pc_plus4),
        .d_instr   (d_instr),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Occupancy of 3 is illegal at any time.
    always @(negedge clk) begin
        if (occupancy === 2'd3) begin
            $display("FAIL occupancy_illegal: got %0d, required 0..2", occupancy);
            errors++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        f_pc = '0; f_instr = '0;
        step(); step();
        vectors++;
        if ({d_valid, occupancy, f_ready} !== ST_EMPTY) begin
            $display("FAIL reset_status: got %b, required %b", {d_valid, occupancy, f_ready}, ST_EMPTY);
            errors++;
        end
        vectors++;
        if (d_instr !== 32'h0) begin
            $display("FAIL reset_instr: got %h, required 00000000", d_instr);
            errors++;
        end
        rst = 1'b0;
        step();
        $display("reset released");
    endtask

    // Three back-to-back transfers followed by a drain, at one instruction per cycle.
    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc  = 32'(4 * i);
            f_valid = 1'b1; f_pc = exp_pc; f_instr = 32'h11110000 + 32'(i);
            step();
            $display("xfer pc=%h pc4=%h instr=%h occ=%0d", d_pc, d_pc_plus4, d_instr, occupancy);
            vectors++;
            if ({d_valid, occupancy, f_ready} !== ST_ONE) begin
                $display("FAIL stream_status[%0d]: got %b, required %b", i, {d_valid, occupancy, f_ready}, ST_ONE);
                errors++;
            end
            vectors++;
            if ({d_pc, d_pc_plus4, d_instr} !== {exp_pc, exp_pc + 32'd4, 32'h11110000 + 32'(i)}) begin
                $display("FAIL stream_data[%0d]: got pc=%h pc4=%h instr=%h, required pc=%h pc4=%h instr=%h",
                         i, d_pc, d_pc_plus4, d_instr, exp_pc, exp_pc + 32'd4, 32'h11110000 + 32'(i));
                errors++;
            end
        end
        f_valid = 1'b0;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
            $display("FAIL stream_drain: got st=%b instr=%h, required st=%b instr=00000000",
                     {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
            errors++;
        end
    endtask

    // A decode stall fills the skid slot. Release the stall and check program order.
    task automatic test_stall();
        d_ready = 1'b0; f_valid = 1'b1; f_pc = 32'h10; f_instr = 32'hA0000010;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_pc} !== {ST_ONE, 32'h10}) begin
            $display("FAIL stall_load: got st=%b pc=%h, required st=%b pc=00000010", {d_valid, occupancy, f_ready}, d_pc, ST_ONE);
            errors++;
        end
        f_pc = 32'h14; f_instr = 32'hA0000014;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_pc} !== {ST_TWO, 32'h10}) begin
            $display("FAIL stall_fill: got st=%b pc=%h, required st=%b pc=00000010", {d_valid, occupancy, f_ready}, d_pc, ST_TWO);
            errors++;
        end
        // While f_ready is low this offer must be ignored.
        f_pc = 32'h18; f_instr = 32'hA0000018;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_pc, d_pc_plus4, d_instr} !== {ST_TWO, 32'h10, 32'h14, 32'hA0000010}) begin
            $display("FAIL stall_hold: got st=%b pc=%h pc4=%h instr=%h, required st=%b pc=00000010 pc4=00000014 instr=a0000010",
                     {d_valid, occupancy, f_ready}, d_pc, d_pc_plus4, d_instr, ST_TWO);
            errors++;
        end
        f_valid = 1'b0; d_ready = 1'b1;
        step();
        $display("xfer pc=%h instr=%h occ=%0d", d_pc, d_instr, occupancy);
        vectors++;
        if ({d_valid, occupancy, f_ready, d_pc, d_instr} !== {ST_ONE, 32'h14, 32'hA0000014}) begin
            $display("FAIL stall_release: got st=%b pc=%h instr=%h, required st=%b pc=00000014 instr=a0000014",
                     {d_valid, occupancy, f_ready}, d_pc, d_instr, ST_ONE);
            errors++;
        end
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
            $display("FAIL stall_drain: got st=%b instr=%h, required st=%b instr=00000000", {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
            errors++;
        end
    endtask

    // Flush with a full buffer, then flush in ONE with an acceptable offer.
    task automatic test_flush();
        d_ready = 1'b0; f_valid = 1'b1; f_pc = 32'h20; f_instr = 32'hB0000020;
        step();
        f_pc = 32'h24; f_instr = 32'hB0000024;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready} !== ST_TWO) begin
            $display("FAIL flush_fill: got %b, required %b", {d_valid, occupancy, f_ready}, ST_TWO);
            errors++;
        end
        flush = 1'b1; f_pc = 32'h28; f_instr = 32'hB0000028;
        step();
        flush = 1'b0; f_valid = 1'b0;
        vectors++;
        if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
            $display("FAIL flush_full: got st=%b instr=%h, required st=%b instr=00000000", {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
            errors++;
        end
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready} !== ST_EMPTY) begin
            $display("FAIL flush_no_ghost: got %b, required %b", {d_valid, occupancy, f_ready}, ST_EMPTY);
            errors++;
        end
        f_valid = 1'b1; f_pc = 32'h40; f_instr = 32'hB0000040;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_pc, d_instr} !== {ST_ONE, 32'h40, 32'hB0000040}) begin
            $display("FAIL flush_refill: got st=%b pc=%h instr=%h, required st=%b pc=00000040 instr=b0000040",
                     {d_valid, occupancy, f_ready}, d_pc, d_instr, ST_ONE);
            errors++;
        end
        // ONE, f_ready high, offer present, consume concurrent: all dropped.
        flush = 1'b1; d_ready = 1'b1; f_pc = 32'h54; f_instr = 32'hB0000054;
        step();
        flush = 1'b0; f_valid = 1'b0;
        vectors++;
        if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
            $display("FAIL flush_drops_offer: got st=%b instr=%h, required st=%b instr=00000000", {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
            errors++;
        end
    endtask

    task automatic test_wrap();
        d_ready = 1'b0; f_valid = 1'b1; f_pc = 32'hFFFFFFFC; f_instr = 32'h8C220004;
        step();
        vectors++;
        if ({d_valid, d_pc, d_pc_plus4, d_instr} !== {1'b1, 32'hFFFFFFFC, 32'h0, 32'h8C220004}) begin
            $display("FAIL wrap: got v=%b pc=%h pc4=%h instr=%h, required v=1 pc=fffffffc pc4=00000000 instr=8c220004",
                     d_valid, d_pc, d_pc_plus4, d_instr);
            errors++;
        end
        f_valid = 1'b0; d_ready = 1'b1;
        step();
    endtask

    // Reset with a full buffer, first alone and then together with flush.
    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            d_ready = 1'b0; f_valid = 1'b1; f_pc = 32'h60; f_instr = 32'hC0000060;
            step();
            f_pc = 32'h64; f_instr = 32'hC0000064;
            step();
            vectors++;
            if ({d_valid, occupancy, f_ready} !== ST_TWO) begin
                $display("FAIL rstmid_fill[%0d]: got %b, required %b", k, {d_valid, occupancy, f_ready}, ST_TWO);
                errors++;
            end
            rst = 1'b1; flush = (k == 1); d_ready = 1'b1; f_valid = 1'b0;
            step();
            rst = 1'b0; flush = 1'b0;
            vectors++;
            if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
                $display("FAIL rstmid[%0d]: got st=%b instr=%h, required st=%b instr=00000000", k, {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
                errors++;
            end
        end
    endtask

    task automatic test_drain();
        d_ready = 1'b0; f_valid = 1'b1; f_pc = 32'h30; f_instr = 32'hD0000030;
        step();
        f_valid = 1'b0; d_ready = 1'b1;
        step();
        vectors++;
        if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
            $display("FAIL drain: got st=%b instr=%h, required st=%b instr=00000000", {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({d_valid, occupancy, f_ready, d_instr} !== {ST_EMPTY, 32'h0}) begin
                $display("FAIL drain_idle[%0d]: got st=%b instr=%h, required st=%b instr=00000000", i, {d_valid, occupancy, f_ready}, d_instr, ST_EMPTY);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
